// File: rtl/capture_buffer_mc_if.sv
// Capture buffer bus: acquisition control, sample input and readout.
// master drives control/samples, slave is the capture buffer itself.
interface capture_buffer_mc_if #(
  parameter int DW  = 14,
  parameter int AW  = 12,
  parameter int NCH = 2,
  parameter int NW  = 4
) ();
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              arm;
  logic              trig;
  logic              force_trig;
  logic [NCH*DW-1:0] din;
  logic [AW-1:0]     pnts_after_trig;
  logic [NW-1:0]     nth;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     rd_ch;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     addr_trig;
  logic              enabled;
  logic              done;

  modport master (
    output arm, trig, force_trig, din,
    output pnts_after_trig, nth, rd_addr, rd_ch,
    input  rd_data, addr_trig, enabled, done
  );

  modport slave (
    input  arm, trig, force_trig, din,
    input  pnts_after_trig, nth, rd_addr, rd_ch,
    output rd_data, addr_trig, enabled, done
  );
endinterface

// File: rtl/capture_buffer_mc.sv
// Multi-channel triggered capture buffer: circular pre-trigger history,
// Nth-edge or forced trigger, programmable post-trigger length, freeze.
module capture_buffer_mc #(
  parameter int DW  = 14,
  parameter int AW  = 12,
  parameter int NCH = 2,
  parameter int NW  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  capture_buffer_mc_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int D  = 1 << AW;

  typedef enum logic [2:0] {
    IDLE, PRE, ARMED, POST, DONE
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_waddr;
  logic [AW:0]     r_pre_cnt;
  logic [AW-1:0]   r_post_cnt;
  logic [NW-1:0]   r_trig_cnt;
  logic [AW-1:0]   r_p;
  logic [NW-1:0]   r_n;
  logic            r_trig_q;
  logic [AW-1:0]   r_addr_trig;
  logic            r_enabled;
  logic            r_done;
  logic [DW-1:0]   r_rd_data;
  logic [DW-1:0]   r_mem [NCH][D];

  logic            w_act;
  logic            w_we;
  logic            w_edge;
  logic            w_hit;
  logic            w_take;
  logic            w_fin;
  logic [NW:0]     w_cnt_nxt;
  logic [AW:0]     w_pre_nxt;
  logic [AW:0]     w_thr;
  logic [AW-1:0]   w_post_nxt;
  logic [AW-1:0]   w_p_in;
  logic [NW-1:0]   w_n_in;
  logic [DW-1:0]   w_rd;

  assign w_act = (r_state == PRE) || (r_state == ARMED) ||
                 (r_state == POST);
  assign w_we  = w_act && !bus.arm;

  assign w_edge    = bus.trig & ~r_trig_q;
  assign w_cnt_nxt = {1'b0, r_trig_cnt} + (NW+1)'(1);
  assign w_hit     = (w_edge && (w_cnt_nxt == {1'b0, r_n})) ||
                     bus.force_trig;
  assign w_take    = ((r_state == PRE) && bus.force_trig) ||
                     ((r_state == ARMED) && w_hit);
  assign w_fin     = (r_p == AW'(1));

  // pre-fill counter saturates at the full depth
  assign w_pre_nxt  = r_pre_cnt[AW] ? r_pre_cnt
                                    : r_pre_cnt + (AW+1)'(1);
  assign w_thr      = (AW+1)'(D) - {1'b0, r_p};
  assign w_post_nxt = r_post_cnt + AW'(1);

  assign w_p_in = (bus.pnts_after_trig == '0) ? AW'(1)
                                              : bus.pnts_after_trig;
  assign w_n_in = (bus.nth == '0) ? NW'(1) : bus.nth;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_waddr     <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_trig_cnt  <= '0;
      r_p         <= '0;
      r_n         <= '0;
      r_trig_q    <= 1'b0;
      r_addr_trig <= '0;
      r_enabled   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_trig_q <= bus.trig;
      if (w_we) r_waddr <= r_waddr + AW'(1);
      if ((r_state == ARMED) && w_edge)
        r_trig_cnt <= w_cnt_nxt[NW-1:0];
      if (bus.arm) begin
        r_state    <= PRE;
        r_enabled  <= 1'b1;
        r_done     <= 1'b0;
        r_waddr    <= '0;
        r_pre_cnt  <= '0;
        r_post_cnt <= '0;
        r_trig_cnt <= '0;
        r_p        <= w_p_in;
        r_n        <= w_n_in;
      end else if (w_take) begin
        r_addr_trig <= r_waddr;
        r_post_cnt  <= AW'(1);
        r_state     <= w_fin ? DONE : POST;
        r_enabled   <= !w_fin;
        r_done      <= w_fin;
      end else begin
        unique case (r_state)
          PRE: begin
            r_pre_cnt <= w_pre_nxt;
            if (w_pre_nxt >= w_thr) r_state <= ARMED;
          end
          POST: begin
            r_post_cnt <= w_post_nxt;
            if (w_post_nxt == r_p) begin
              r_state   <= DONE;
              r_enabled <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int c = 0; c < NCH; c++)
        r_mem[c][r_waddr] <= bus.din[c*DW +: DW];
    end
  end

  // out-of-range channel select reads as zero
  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NCH; c++)
      if (bus.rd_ch == CW'(c)) w_rd = r_mem[c][bus.rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_data <= '0;
    else       r_rd_data <= w_rd;
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.addr_trig = r_addr_trig;
  assign bus.enabled   = r_enabled;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_capture_buffer_mc.sv
// Directed bench for capture_buffer_mc with AW=4, NCH=3.
// Sample value of write j (after arm) is base+j, channel c adds c*1000.
module tb_capture_buffer_mc;
  localparam int DW  = 14;
  localparam int AW  = 4;
  localparam int NCH = 3;
  localparam int NW  = 4;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ramp  = 0;

  always #5 clk = ~clk;

  capture_buffer_mc_if #(
    .DW(DW), .AW(AW), .NCH(NCH), .NW(NW)
  ) bus ();

  capture_buffer_mc #(
    .DW(DW), .AW(AW), .NCH(NCH), .NW(NW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mk(input int r);
    for (int c = 0; c < NCH; c++)
      bus.din[c*DW +: DW] = DW'(r + c * 1000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ramp++;
    mk(ramp);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic arm_cap(input int p, input int n, input int base);
    bus.pnts_after_trig = AW'(p);
    bus.nth = NW'(n);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    ramp = base;
    mk(base);
  endtask

  task automatic rd(input int a, input int ch,
                    input int exp, input string tag);
    bus.rd_addr = AW'(a);
    bus.rd_ch   = 2'(ch);
    step();
    chk(tag, 32'(bus.rd_data), exp);
  endtask

  initial begin
    rstn = 1'b0;
    bus.arm = 1'b0;
    bus.trig = 1'b0;
    bus.force_trig = 1'b0;
    bus.pnts_after_trig = '0;
    bus.nth = '0;
    bus.rd_addr = '0;
    bus.rd_ch = '0;
    mk(0);
    run(2);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_addr_trig", 32'(bus.addr_trig), 0);
    chk("rst_enabled", 32'(bus.enabled), 0);
    chk("rst_done", 32'(bus.done), 0);
    rstn = 1'b1;
    step();

    // basic capture: P=4, N=1, trigger after 20 writes
    arm_cap(4, 1, 0);
    chk("s1_en", 32'(bus.enabled), 1);
    chk("s1_done0", 32'(bus.done), 0);
    run(20);
    bus.trig = 1'b1;
    step();
    chk("s1_atrig", 32'(bus.addr_trig), 4);
    chk("s1_done1", 32'(bus.done), 0);
    chk("s1_en1", 32'(bus.enabled), 1);
    run(2);
    chk("s1_done2", 32'(bus.done), 0);
    step();
    chk("s1_done3", 32'(bus.done), 1);
    chk("s1_en3", 32'(bus.enabled), 0);
    bus.trig = 1'b0;
    run(2);
    chk("s1_hold", 32'(bus.done), 1);
    rd(4, 0, 20, "s1_trig_c0");
    rd(4, 1, 1020, "s1_trig_c1");
    rd(8, 2, 2008, "s1_old_c2");
    rd(7, 0, 23, "s1_new_c0");
    rd(8, 0, 8, "s1_old_c0");
    rd(0, 0, 16, "s1_a0_c0");
    rd(4, 3, 0, "s1_bad_ch");

    // edge during pre-fill is ignored
    arm_cap(4, 1, 0);
    chk("s2_done0", 32'(bus.done), 0);
    run(4);
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
    run(7);
    chk("s2_pre_done", 32'(bus.done), 0);
    chk("s2_pre_en", 32'(bus.enabled), 1);
    bus.trig = 1'b1;
    step();
    chk("s2_atrig", 32'(bus.addr_trig), 12);
    bus.trig = 1'b0;
    run(3);
    chk("s2_done", 32'(bus.done), 1);

    // N=3: third edge in ARMED is taken
    arm_cap(2, 3, 0);
    run(14);
    bus.trig = 1'b1; step();
    bus.trig = 1'b0; step();
    bus.trig = 1'b1; step();
    bus.trig = 1'b0; step();
    chk("s3_atrig_held", 32'(bus.addr_trig), 12);
    chk("s3_done_pre", 32'(bus.done), 0);
    bus.trig = 1'b1; step();
    chk("s3_atrig", 32'(bus.addr_trig), 2);
    chk("s3_en", 32'(bus.enabled), 1);
    bus.trig = 1'b0; step();
    chk("s3_done", 32'(bus.done), 1);
    rd(2, 0, 18, "s3_trig_c0");

    // N=0 behaves as N=1
    arm_cap(2, 0, 0);
    run(14);
    bus.trig = 1'b1; step();
    chk("s3b_atrig", 32'(bus.addr_trig), 14);
    bus.trig = 1'b0; step();
    chk("s3b_done", 32'(bus.done), 1);

    // forced trigger during pre-fill
    arm_cap(3, 1, 0);
    run(5);
    bus.force_trig = 1'b1; step();
    bus.force_trig = 1'b0;
    chk("s4_atrig", 32'(bus.addr_trig), 5);
    chk("s4_en", 32'(bus.enabled), 1);
    chk("s4_done0", 32'(bus.done), 0);
    step();
    chk("s4_done1", 32'(bus.done), 0);
    step();
    chk("s4_done2", 32'(bus.done), 1);
    rd(5, 1, 1005, "s4_trig_c1");

    // P=0 acts as P=1: done right after trigger write
    arm_cap(0, 1, 0);
    run(15);
    bus.trig = 1'b1; step();
    bus.trig = 1'b0;
    chk("s5_done", 32'(bus.done), 1);
    chk("s5_en", 32'(bus.enabled), 0);
    chk("s5_atrig", 32'(bus.addr_trig), 15);
    run(3);
    rd(0, 0, 0, "s5_frozen_a0");

    // P=1 with forced trigger
    arm_cap(1, 1, 100);
    run(3);
    bus.force_trig = 1'b1; step();
    bus.force_trig = 1'b0;
    chk("s5b_done", 32'(bus.done), 1);
    chk("s5b_atrig", 32'(bus.addr_trig), 3);
    run(2);
    rd(4, 0, 4, "s5b_untouched");
    rd(3, 0, 103, "s5b_trig_c0");

    // re-arm during POST restarts at address 0
    arm_cap(4, 1, 0);
    run(12);
    bus.trig = 1'b1; step();
    bus.trig = 1'b0; step();
    chk("s6_post_en", 32'(bus.enabled), 1);
    arm_cap(4, 1, 200);
    chk("s6_rearm_en", 32'(bus.enabled), 1);
    chk("s6_rearm_done", 32'(bus.done), 0);
    rd(0, 0, 0, "s6_read_first");
    rd(0, 0, 200, "s6_rearm_a0");
    chk("s6_no_done", 32'(bus.done), 0);
    run(10);
    chk("s6_armed_en", 32'(bus.enabled), 1);

    // async reset while ARMED
    rstn = 1'b0;
    #1;
    chk("s6_rst_en", 32'(bus.enabled), 0);
    chk("s6_rst_done", 32'(bus.done), 0);
    chk("s6_rst_atrig", 32'(bus.addr_trig), 0);
    chk("s6_rst_rd", 32'(bus.rd_data), 0);
    step();
    rstn = 1'b1;
    step();
    bus.trig = 1'b1; step();
    bus.trig = 1'b0; step();
    chk("s6_idle_en", 32'(bus.enabled), 0);
    chk("s6_idle_done", 32'(bus.done), 0);
    chk("s6_idle_atrig", 32'(bus.addr_trig), 0);
    rd(4, 3, 0, "s6_bad_ch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
